// File: rtl/layer2_argmax.sv
// Layer 2 output sequencer: runs the shared neuron once per class and keeps the running argmax.
// Optional score readback buffer enabled by defining LAYER2_ARGMAX_SCORES_EN.
module layer2_argmax #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned LOGIT_W     = 6,
  parameter int unsigned IDX_W       = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               neuron_start_o,
  input  logic               neuron_done_i,
  input  logic [LOGIT_W-1:0] neuron_result_i,
  output logic [IDX_W-1:0]   class_idx_o,
  output logic               busy_o,
  output logic               valid_o,
  output logic [IDX_W-1:0]   pred_class_o,
  output logic [LOGIT_W-1:0] pred_logit_o,
  input  logic [IDX_W-1:0]   score_sel_i,
  output logic [LOGIT_W-1:0] score_out_o
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   class_idx_q, class_idx_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               neuron_start_q, neuron_start_d;
  logic [IDX_W-1:0]   pred_class_q, pred_class_d;
  logic [LOGIT_W-1:0] pred_logit_q, pred_logit_d;
  logic [LOGIT_W-1:0] max_q, max_d;
  logic               capture_c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      class_idx_q    <= '0;
      busy_q         <= 1'b0;
      valid_q        <= 1'b0;
      neuron_start_q <= 1'b0;
      pred_class_q   <= '0;
      pred_logit_q   <= '0;
      max_q          <= '0;
    end else begin
      state_q        <= state_d;
      class_idx_q    <= class_idx_d;
      busy_q         <= busy_d;
      valid_q        <= valid_d;
      neuron_start_q <= neuron_start_d;
      pred_class_q   <= pred_class_d;
      pred_logit_q   <= pred_logit_d;
      max_q          <= max_d;
    end
  end

  // Sequencing and capture; class_idx is held through DRAIN so weights stay stable.
  always_comb begin
    state_d        = state_q;
    class_idx_d    = class_idx_q;
    busy_d         = busy_q;
    valid_d        = valid_q;
    neuron_start_d = 1'b0;
    pred_class_d   = pred_class_q;
    pred_logit_d   = pred_logit_q;
    max_d          = max_q;
    capture_c      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          class_idx_d    = '0;
          busy_d         = 1'b1;
          valid_d        = 1'b0;
          neuron_start_d = 1'b1;
          state_d        = ST_RUN;
        end
      end
      ST_RUN: begin
        neuron_start_d = 1'b1;
        if (neuron_done_i) begin
          capture_c      = 1'b1;
          neuron_start_d = 1'b0;
          state_d        = ST_DRAIN;
          // Strict compare: ties keep the lower class index.
          if (class_idx_q == '0 || $signed(neuron_result_i) > $signed(max_q)) begin
            max_d        = neuron_result_i;
            pred_class_d = class_idx_q;
          end
        end
      end
      ST_DRAIN: begin
        if (!neuron_done_i) begin
          if (class_idx_q == LAST_IDX) begin
            state_d = ST_FINISH;
          end else begin
            class_idx_d    = class_idx_q + 1'b1;
            neuron_start_d = 1'b1;
            state_d        = ST_RUN;
          end
        end
      end
      ST_FINISH: begin
        pred_logit_d = max_q;
        valid_d      = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign neuron_start_o = neuron_start_q;
  assign class_idx_o    = class_idx_q;
  assign busy_o         = busy_q;
  assign valid_o        = valid_q;
  assign pred_class_o   = pred_class_q;
  assign pred_logit_o   = pred_logit_q;

`ifdef LAYER2_ARGMAX_SCORES_EN
  logic [LOGIT_W-1:0] scores_q [NUM_CLASSES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_CLASSES); i++) scores_q[i] <= '0;
    end else if (capture_c) begin
      scores_q[class_idx_q] <= neuron_result_i;
    end
  end

  // Out-of-range selects read as zero.
  always_comb begin
    score_out_o = '0;
    if (32'(score_sel_i) < NUM_CLASSES) score_out_o = scores_q[score_sel_i];
  end
`else
  logic unused_score;
  assign unused_score = ^{score_sel_i, capture_c};
  assign score_out_o  = '0;
`endif

endmodule
